// File: rtl/jk_ff.sv
// jk_ff: array of WIDTH independent positive-edge JK flip-flops,
// asynchronous active-high reset to RESET_VALUE.
//
// Ports:
//   clk  - clock, state updates on rising edge
//   rst  - async active-high reset, forces q to RESET_VALUE
//   j    - per-bit set control
//   k    - per-bit reset control
//   q    - registered state, straight from the flops
//   q_n  - combinational complement of q
module jk_ff #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Characteristic equation, bitwise so bits never interact:
   // 00 hold, 01 clear, 10 set, 11 toggle.
   always_comb begin
      q_d = (j & ~q_q) | (~k & q_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   // No logic between the storage element and q.
   assign q   = q_q;
   assign q_n = ~q_q;

endmodule

// File: tb/tb_jk_ff.sv
// tb_jk_ff: directed plus random checks of jk_ff at WIDTH=1 and
// WIDTH=4 (RESET_VALUE=4'b1010) against a truth-table model.
module tb_jk_ff;

   logic       clk;
   logic       rst;
   logic       j1, k1;
   logic       q1, qn1;
   logic [3:0] j4, k4;
   logic [3:0] q4, qn4;

   logic       m1;
   logic [3:0] m4;
   logic       started;

   int tests;
   int fails;

   jk_ff u1 (
      .clk (clk),
      .rst (rst),
      .j   (j1),
      .k   (k1),
      .q   (q1),
      .q_n (qn1)
   );

   jk_ff #(
      .WIDTH       (4),
      .RESET_VALUE (4'b1010)
   ) u4 (
      .clk (clk),
      .rst (rst),
      .j   (j4),
      .k   (k4),
      .q   (q4),
      .q_n (qn4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Truth table of one JK bit, as listed in a datasheet.
   function automatic logic jk_next(input logic cur,
                                    input logic jj,
                                    input logic kk);
      logic [1:0] sel;
      sel = {jj, kk};
      case (sel)
         2'b00:   return cur;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~cur;
      endcase
   endfunction

   // Reference model: reset is immediate, otherwise one table
   // lookup per bit on each rising edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1 <= 1'b0;
         m4 <= 4'b1010;
      end else begin
         m1 <= jk_next(m1, j1, k1);
         for (int b = 0; b < 4; b++)
            m4[b] <= jk_next(m4[b], j4[b], k4[b]);
      end
   end

   task automatic chk(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %b want %b", nm, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison, away from the rising edge.
   always @(negedge clk) begin
      if (started) begin
         chk("cyc_q1",  {3'b0, q1},  {3'b0, m1});
         chk("cyc_qn1", {3'b0, qn1}, {3'b0, ~m1});
         chk("cyc_q4",  q4,  m4);
         chk("cyc_qn4", qn4, ~m4);
      end
   end

   task automatic tick(input logic a, input logic b,
                       input logic [3:0] c, input logic [3:0] d);
      @(negedge clk);
      #1;
      j1 = a;
      k1 = b;
      j4 = c;
      k4 = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      started = 1'b0;
      rst     = 1'b0;
      j1 = 1'b1; k1 = 1'b1;
      j4 = 4'hf; k4 = 4'hf;
      #1 rst = 1'b1;
      #1 started = 1'b1;

      // Reset held with j=k=1 and clock running.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_q",   {3'b0, q1},  4'b0000);
         chk("rst_qn",  {3'b0, qn1}, 4'b0001);
         chk("rst_q4",  q4,  4'b1010);
         chk("rst_qn4", qn4, 4'b0101);
      end
      @(negedge clk);
      #1;
      rst = 1'b0;
      j1 = 1'b0; k1 = 1'b0;
      j4 = 4'h0; k4 = 4'h0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("rel_hold", {3'b0, q1}, 4'b0000);
      end

      // Clear, set, hold.
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b1, 4'h0, 4'h0);
         chk("clr", {3'b0, q1}, 4'b0000);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b0, 4'h0, 4'h0);
         chk("set", {3'b0, q1}, 4'b0001);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0, 4'h0, 4'h0);
         chk("hold", {3'b0, q1}, 4'b0001);
      end

      // Toggle: 0,1,0,1.
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b1, 4'h0, 4'h0);
         chk("tog_q",  {3'b0, q1},  {3'b0, i[0]});
         chk("tog_qn", {3'b0, qn1}, {3'b0, ~i[0]});
      end

      // Async reset between edges, q=1 beforehand.
      @(posedge clk);
      j1 = 1'b0; k1 = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("async_q",  {3'b0, q1},  4'b0000);
      chk("async_qn", {3'b0, qn1}, 4'b0001);
      chk("async_q4", q4, 4'b1010);
      @(negedge clk);
      #1;
      rst = 1'b0;
      j1 = 1'b1; k1 = 1'b0;
      @(posedge clk);
      #1;
      chk("async_rel", {3'b0, q1}, 4'b0001);

      // Mid-cycle pulse on j must be ignored.
      tick(1'b0, 1'b1, 4'h0, 4'h0);
      chk("pre_pulse", {3'b0, q1}, 4'b0000);
      #1;
      k1 = 1'b0;
      #1;
      j1 = 1'b1;
      #2;
      j1 = 1'b0;
      @(posedge clk);
      #1;
      chk("pulse_q", {3'b0, q1}, 4'b0000);

      // Multi-bit: hold, clear, set, toggle from 1010.
      chk("mb_rst", q4, 4'b1010);
      tick(1'b0, 1'b0, 4'b0011, 4'b0101);
      chk("mb_q",  q4,  4'b1011);
      chk("mb_qn", qn4, 4'b0100);

      // Random phase with occasional async reset pulses.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            @(posedge clk);
            if ($urandom_range(0, 1) == 1) #7;
            else #3;
            rst = 1'b1;
            @(negedge clk);
            #1;
            rst = 1'b0;
         end
         tick(1'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom));
      end

      @(negedge clk);
      #1;
      started = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
